// File: rtl/sd_cmd_sched_if.sv
// Issue/response bus between the command scheduler and the CMD-line engine.
interface sd_cmd_sched_if;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic [5:0]  cmd_index_o;
    logic [31:0] cmd_arg_o;
    logic [1:0]  cmd_resp_type_o;
    logic        cmd_end_i;
    logic        cmd_done_i;
    logic        cmd_error_i;

    modport master (
        output cmd_valid_o, cmd_index_o, cmd_arg_o, cmd_resp_type_o,
        input  cmd_ready_i, cmd_end_i, cmd_done_i, cmd_error_i
    );

    modport slave (
        input  cmd_valid_o, cmd_index_o, cmd_arg_o, cmd_resp_type_o,
        output cmd_ready_i, cmd_end_i, cmd_done_i, cmd_error_i
    );
endinterface

// File: rtl/sd_cmd_sched.sv
// Arbitrates host commands and Auto CMD12 onto the CMD engine, enforces DAT
// inhibit, supervises responses with a watchdog and emits completion pulses.
module sd_cmd_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic        sdclk_i,
    input  logic        rst_i,
    input  logic        host_req_i,
    input  logic [5:0]  host_index_i,
    input  logic [31:0] host_arg_i,
    input  logic [1:0]  host_resp_type_i,
    input  logic        host_data_present_i,
    input  logic [1:0]  host_cmd_type_i,
    output logic        host_reject_o,
    input  logic        auto_cmd12_issue_i,
    input  logic        dat_line_active_i,
    output logic        cmd_inhibit_o,
    output logic        dat_inhibit_o,
    sd_cmd_sched_if.master eng,
    output logic [1:0]  resp_type_o,
    output logic        data_present_o,
    output logic [1:0]  cmd_type_o,
    output logic        command_end_o,
    output logic        command_complete_o,
    output logic        auto_cmd12_complete_o,
    output logic        host_done_o,
    output logic        host_error_o,
    output logic        auto_error_o,
    output logic        watchdog_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SENT, S_RESP} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              auto_pend_q, auto_pend_d;
    logic              slot_q, slot_d;
    logic              elig_q, elig_d;
    logic [5:0]        slot_idx_q, slot_idx_d;
    logic [31:0]       slot_arg_q, slot_arg_d;
    logic [1:0]        slot_resp_q, slot_resp_d;
    logic              slot_dp_q, slot_dp_d;
    logic [1:0]        slot_ct_q, slot_ct_d;
    logic [5:0]        cmd_idx_q, cmd_idx_d;
    logic [31:0]       cmd_arg_q, cmd_arg_d;
    logic [1:0]        cmd_resp_q, cmd_resp_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic              reject_q, reject_d;
    logic              ok_ev, err_ev;

    // Next state, slot bookkeeping and the combinational status pulses
    always_comb begin
        state_d               = state_q;
        owner_d               = owner_q;
        auto_pend_d           = auto_pend_q;
        slot_d                = slot_q;
        slot_idx_d            = slot_idx_q;
        slot_arg_d            = slot_arg_q;
        slot_resp_d           = slot_resp_q;
        slot_dp_d             = slot_dp_q;
        slot_ct_d             = slot_ct_q;
        cmd_idx_d             = cmd_idx_q;
        cmd_arg_d             = cmd_arg_q;
        cmd_resp_d            = cmd_resp_q;
        wd_cnt_d              = wd_cnt_q;
        reject_d              = host_req_i & slot_q;
        ok_ev                 = 1'b0;
        err_ev                = 1'b0;
        command_end_o         = 1'b0;
        command_complete_o    = 1'b0;
        auto_cmd12_complete_o = 1'b0;
        host_done_o           = 1'b0;
        host_error_o          = 1'b0;
        auto_error_o          = 1'b0;
        watchdog_o            = 1'b0;

        if (host_req_i && !slot_q) begin
            slot_d      = 1'b1;
            slot_idx_d  = host_index_i;
            slot_arg_d  = host_arg_i;
            slot_resp_d = host_resp_type_i;
            slot_dp_d   = host_data_present_i;
            slot_ct_d   = host_cmd_type_i;
        end

        case (state_q)
            S_IDLE: begin
                if (auto_pend_q) begin
                    auto_pend_d = 1'b0;
                    owner_d     = 1'b1;
                    cmd_idx_d   = 6'd12;
                    cmd_arg_d   = 32'd0;
                    cmd_resp_d  = 2'b11;
                    state_d     = S_ISSUE;
                end else if (elig_q) begin
                    owner_d    = 1'b0;
                    cmd_idx_d  = slot_idx_q;
                    cmd_arg_d  = slot_arg_q;
                    cmd_resp_d = slot_resp_q;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (eng.cmd_ready_i) state_d = S_SENT;
            end
            S_SENT: begin
                if (eng.cmd_end_i) begin
                    command_end_o = !owner_q;
                    if (cmd_resp_q == 2'b00) begin
                        ok_ev   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wd_cnt_d = '0;
                        state_d  = S_RESP;
                    end
                end
            end
            S_RESP: begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
                if (eng.cmd_error_i) begin
                    err_ev = 1'b1;
                end else if (eng.cmd_done_i) begin
                    ok_ev = 1'b1;
                end else if (wd_cnt_q == WD_LAST) begin
                    watchdog_o = 1'b1;
                    err_ev     = 1'b1;
                end
                if (ok_ev || err_ev) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (ok_ev) begin
            if (owner_q) begin
                auto_cmd12_complete_o = 1'b1;
            end else begin
                command_complete_o = 1'b1;
                host_done_o        = 1'b1;
                slot_d             = 1'b0;
            end
        end
        if (err_ev) begin
            if (owner_q) begin
                auto_error_o = 1'b1;
            end else begin
                host_error_o = 1'b1;
                slot_d       = 1'b0;
            end
        end

        if (auto_cmd12_issue_i) auto_pend_d = 1'b1;

        // Eligibility is registered, so a DAT-line release is acted on one cycle later
        elig_d = slot_d & (!(slot_dp_d || slot_resp_d == 2'b11) || !dat_line_active_i
                           || slot_ct_d == 2'b11);
    end

    always_ff @(posedge sdclk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            auto_pend_q <= 1'b0;
            slot_q      <= 1'b0;
            elig_q      <= 1'b0;
            slot_idx_q  <= '0;
            slot_arg_q  <= '0;
            slot_resp_q <= '0;
            slot_dp_q   <= 1'b0;
            slot_ct_q   <= '0;
            cmd_idx_q   <= '0;
            cmd_arg_q   <= '0;
            cmd_resp_q  <= '0;
            wd_cnt_q    <= '0;
            reject_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            auto_pend_q <= auto_pend_d;
            slot_q      <= slot_d;
            elig_q      <= elig_d;
            slot_idx_q  <= slot_idx_d;
            slot_arg_q  <= slot_arg_d;
            slot_resp_q <= slot_resp_d;
            slot_dp_q   <= slot_dp_d;
            slot_ct_q   <= slot_ct_d;
            cmd_idx_q   <= cmd_idx_d;
            cmd_arg_q   <= cmd_arg_d;
            cmd_resp_q  <= cmd_resp_d;
            wd_cnt_q    <= wd_cnt_d;
            reject_q    <= reject_d;
        end
    end

    assign eng.cmd_valid_o     = (state_q == S_ISSUE);
    assign eng.cmd_index_o     = cmd_idx_q;
    assign eng.cmd_arg_o       = cmd_arg_q;
    assign eng.cmd_resp_type_o = cmd_resp_q;
    assign host_reject_o       = reject_q;
    assign cmd_inhibit_o       = slot_q;
    assign dat_inhibit_o       = dat_line_active_i | (slot_q & (slot_dp_q | (slot_resp_q == 2'b11)));
    assign resp_type_o         = slot_resp_q;
    assign data_present_o      = slot_dp_q;
    assign cmd_type_o          = slot_ct_q;
endmodule
